// File: rtl/reg_xfer_sequencer_if.sv
// Register-transfer request/strobe bundle between a requester and the
// sequencer. The requester (master) drives the operands; the sequencer
// (slave) returns status and the per-register sel/ld strobes.
interface reg_xfer_if #(
  parameter int N_REGS = 8
);
  logic              req;
  logic              op_alu;
  logic [2:0]        src;
  logic [2:0]        dst;
  logic              busy;
  logic              done;
  logic              err;
  logic [N_REGS-1:0] sel;
  logic [N_REGS-1:0] ld;
  logic              alu_drive;

  modport master (
    output req, op_alu, src, dst,
    input  busy, done, err, sel, ld, alu_drive
  );

  modport slave (
    input  req, op_alu, src, dst,
    output busy, done, err, sel, ld, alu_drive
  );
endinterface

// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: sequences one register-file write at a time
// (MOV8, clear, ALU load) and produces the sel/ld strobes so the bus
// source settles before ld rises and stays driven after ld falls.
// Optional build macro: SINGLE_STEP_EN adds a 'step' input; every
// phase advance then waits for step=1.

// Per-register strobe decode: one instance per register slot.
module reg_xfer_strobe_lane #(
  parameter int IDX = 0
) (
  input  logic       drive_mov,
  input  logic       latch,
  input  logic [2:0] src,
  input  logic [2:0] dst,
  output logic       sel_bit,
  output logic       ld_bit
);
  localparam logic [2:0] ID = 3'(IDX);

  assign sel_bit = drive_mov && (src == ID);
  assign ld_bit  = latch && (dst == ID);
endmodule

module reg_xfer_sequencer #(
  parameter int N_REGS = 8,
  parameter int SETTLE = 2,
  parameter int HOLD   = 1
) (
  input logic        clk,
  input logic        reset,
`ifdef SINGLE_STEP_EN
  input logic        step,
`endif
  reg_xfer_if.slave  bus
);
  localparam int         CNT_W     = 4;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD - 1);
  localparam logic [2:0] IDX_A     = 3'd0;
  localparam logic [2:0] IDX_D     = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_LATCH   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_alu_q, op_alu_d;
  logic [2:0]        src_q, src_d;
  logic [2:0]        dst_q, dst_d;

  logic [N_REGS-1:0] sel_q, sel_d;
  logic [N_REGS-1:0] ld_q, ld_d;
  logic              alu_drive_q, alu_drive_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              adv;
  logic              reject;
  logic              driving;
  logic              drive_mov;
  logic              latch;
  logic [N_REGS-1:0] sel_lane;
  logic [N_REGS-1:0] ld_lane;

  // Phase-advance qualifier: free-running unless single-step is built in.
`ifdef SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // State register: FSM, counter, captured operands and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_alu_q    <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      sel_q       <= '0;
      ld_q        <= '0;
      alu_drive_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_alu_q    <= op_alu_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      sel_q       <= sel_d;
      ld_q        <= ld_d;
      alu_drive_q <= alu_drive_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: acceptance/rejection in IDLE, counted phases after.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_alu_d = op_alu_q;
    src_d    = src_q;
    dst_d    = dst_q;
    reject   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Acceptance depends on req only; step does not gate it.
        if (bus.req) begin
          if (bus.op_alu && (bus.dst != IDX_A) && (bus.dst != IDX_D)) begin
            reject = 1'b1;
          end else begin
            op_alu_d = bus.op_alu;
            src_d    = bus.src;
            dst_d    = bus.dst;
            cnt_d    = SETTLE_LD;
            state_d  = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (adv) begin
          if (cnt_q == '0) state_d = S_LATCH;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_LATCH: begin
        if (adv) begin
          cnt_d   = HOLD_LD;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (adv) begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        // req seen here is deliberately ignored; it is taken in IDLE next.
        if (adv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-register sel/ld decode, one lane per register.
  for (genvar i = 0; i < N_REGS; i++) begin : g_lane
    reg_xfer_strobe_lane #(.IDX(i)) u_lane (
      .drive_mov (drive_mov),
      .latch     (latch),
      .src       (src_d),
      .dst       (dst_d),
      .sel_bit   (sel_lane[i]),
      .ld_bit    (ld_lane[i])
    );
  end

  // Output decode from the upcoming state so outputs are plain flops that
  // line up with the state they describe.
  always_comb begin
    driving     = (state_d == S_DRIVE) || (state_d == S_LATCH) ||
                  (state_d == S_RELEASE);
    // A clear leaves the bus undriven (reads 0): no sel for src==dst.
    drive_mov   = driving && !op_alu_d && (src_d != dst_d);
    latch       = (state_d == S_LATCH);
    sel_d       = sel_lane;
    ld_d        = ld_lane;
    alu_drive_d = driving && op_alu_d;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    err_d       = reject;
  end

  assign bus.sel       = sel_q;
  assign bus.ld        = ld_q;
  assign bus.alu_drive = alu_drive_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Bus-ownership invariants on the registered strobes.
  a_sel_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(sel_q));
  a_ld_onehot0  : assert property (@(posedge clk) disable iff (reset)
    $onehot0(ld_q));
  a_ld_in_latch : assert property (@(posedge clk) disable iff (reset)
    (|ld_q) |-> (state_q == S_LATCH));
  a_one_driver  : assert property (@(posedge clk) disable iff (reset)
    !((|sel_q) && alu_drive_q));
  a_src_stable  : assert property (@(posedge clk) disable iff (reset)
    (|ld_q) |-> ($stable(sel_q) && $stable(alu_drive_q)));
endmodule
